// File: rtl/sram_arb_pkg.sv
// Shared types and the round-robin winner search for the SRAM Avalon-MM arbiter.
package sram_arb_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int MAX_ID_W    = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] idx;
    } rr_pick_t;

    // First requester found when scanning n masters upward from ptr, wrapping at n.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [MAX_ID_W-1:0]    ptr,
        input int                     n
    );
        rr_pick_t pick;
        int       cand;
        pick = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            cand = (int'(ptr) + i) % n;
            if (i < n && !pick.valid && req[cand]) begin
                pick.valid = 1'b1;
                pick.idx   = cand[MAX_ID_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sram_arb_id_fifo.sv
// In-order FIFO of master IDs for reads issued but not yet answered.
// DEPTH must be a power of two so the pointers wrap naturally.
module sram_arb_id_fifo
    import sram_arb_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;

    // Full is a registered flag, so a pop cannot free a slot for a push in the same cycle.
    assign w_push = i_push & ~r_full;
    assign w_pop  = i_pop & ~r_empty;

    always_comb begin
        // NOTE: default assigned first so every path drives the signal and no latch is inferred.
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/sram_amm_arbiter.sv
// Shares one Avalon-MM slave between MASTERS_CNT masters, one command per grant.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module sram_amm_arbiter
    import sram_arb_pkg::*;
#(
    parameter int MASTERS_CNT = 2,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [MASTERS_CNT-1:0][ADDR_W-1:0] m_address_i,
    input  logic [MASTERS_CNT-1:0]             m_read_i,
    input  logic [MASTERS_CNT-1:0]             m_write_i,
    input  logic [MASTERS_CNT-1:0][DATA_W-1:0] m_writedata_i,
    output logic [MASTERS_CNT-1:0]             m_waitrequest_o,
    output logic [MASTERS_CNT-1:0]             m_readdatavalid_o,
    output logic [DATA_W-1:0]                  m_readdata_o,
    output logic [ADDR_W-1:0]                  s_address_o,
    output logic                               s_read_o,
    output logic                               s_write_o,
    output logic [DATA_W-1:0]                  s_writedata_o,
    input  logic                               s_waitrequest_i,
    input  logic                               s_readdatavalid_i,
    input  logic [DATA_W-1:0]                  s_readdata_i
);

    localparam int ID_W = $clog2(MASTERS_CNT);

    arb_state_t                r_state;
    arb_state_t                w_state_next;
    logic [ID_W-1:0]           r_grant_id;
    logic [ID_W-1:0]           w_grant_id;
    logic                      w_grant_valid;
    logic [MASTERS_CNT-1:0]    w_req;
    logic [MAX_MASTERS-1:0]    w_req_ext;
    logic [MAX_ID_W-1:0]       w_ptr_ext;
    rr_pick_t                  w_pick;
    logic                      w_is_read;
    logic                      w_is_write;
    logic                      w_throttle;
    logic                      w_accept;
    logic                      w_fifo_push;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [ID_W-1:0]           w_head;

    assign w_req     = m_read_i | m_write_i;
    assign w_req_ext = MAX_MASTERS'(w_req);

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign w_ptr_ext = '0;
`else
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] w_rr_next;

    assign w_ptr_ext = MAX_ID_W'(r_rr_ptr);
    assign w_rr_next = (w_grant_id == ID_W'(MASTERS_CNT - 1)) ? '0 : w_grant_id + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= w_rr_next;
        end
    end
`endif

    assign w_pick = rr_pick(w_req_ext, w_ptr_ext, MASTERS_CNT);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_grant_id <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_state_next == LOCKED) r_grant_id <= w_grant_id;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_grant_valid   = 1'b0;
        w_grant_id      = '0;
        s_read_o        = 1'b0;
        s_write_o       = 1'b0;
        m_waitrequest_o = '1;

        case (r_state)
            IDLE: begin
                w_grant_valid = w_pick.valid;
                w_grant_id    = ID_W'(w_pick.idx);
            end
            LOCKED: begin
                // A master stalled by waitrequest keeps its command, so the grant stays put.
                w_grant_valid = w_req[r_grant_id];
                w_grant_id    = r_grant_id;
            end
            default: ;
        endcase

        // Read wins if a master illegally raises both strobes.
        w_is_read  = w_grant_valid & m_read_i[w_grant_id];
        w_is_write = w_grant_valid & ~m_read_i[w_grant_id] & m_write_i[w_grant_id];
        w_throttle = w_is_read & w_fifo_full;

        s_address_o   = m_address_i[w_grant_id];
        s_writedata_o = m_writedata_i[w_grant_id];

        if (rst_i) begin
            s_read_o  = w_is_read & ~w_throttle;
            s_write_o = w_is_write;
            if (w_grant_valid) m_waitrequest_o[w_grant_id] = s_waitrequest_i | w_throttle;
        end

        w_accept = (s_read_o | s_write_o) & ~s_waitrequest_i;

        case (r_state)
            IDLE:    if (w_grant_valid && !w_accept) w_state_next = LOCKED;
            LOCKED:  if (w_accept || !w_grant_valid) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_fifo_push = s_read_o & ~s_waitrequest_i;

    sram_arb_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_PENDING)
    ) u_id_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_fifo_push),
        .i_pop   (s_readdatavalid_i),
        .i_data  (w_grant_id),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Read data returns in issue order; an unexpected valid with nothing pending is dropped.
    always_comb begin
        m_readdatavalid_o = '0;
        if (rst_i && s_readdatavalid_i && !w_fifo_empty) m_readdatavalid_o[w_head] = 1'b1;
    end

    assign m_readdata_o = s_readdata_i;

`ifndef SYNTHESIS
    a_rdv_without_pending_read : assert property (
        @(posedge clk_i) disable iff (!rst_i) !(s_readdatavalid_i && w_fifo_empty)
    );
`endif

endmodule

// File: tb/tb_sram_amm_arbiter.sv
// Self-checking bench for sram_amm_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_sram_amm_arbiter;

    localparam int N  = 2;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int MP = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0][AW-1:0] m_address;
    logic [N-1:0]        m_read;
    logic [N-1:0]        m_write;
    logic [N-1:0][DW-1:0] m_writedata;
    logic [N-1:0]        m_waitrequest;
    logic [N-1:0]        m_readdatavalid;
    logic [DW-1:0]       m_readdata;
    logic [AW-1:0]       s_address;
    logic                s_read;
    logic                s_write;
    logic [DW-1:0]       s_writedata;
    logic                s_waitrequest;
    logic                s_readdatavalid;
    logic [DW-1:0]       s_readdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sram_amm_arbiter #(
        .MASTERS_CNT (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_PENDING (MP)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .m_address_i       (m_address),
        .m_read_i          (m_read),
        .m_write_i         (m_write),
        .m_writedata_i     (m_writedata),
        .m_waitrequest_o   (m_waitrequest),
        .m_readdatavalid_o (m_readdatavalid),
        .m_readdata_o      (m_readdata),
        .s_address_o       (s_address),
        .s_read_o          (s_read),
        .s_write_o         (s_write),
        .s_writedata_o     (s_writedata),
        .s_waitrequest_i   (s_waitrequest),
        .s_readdatavalid_i (s_readdatavalid),
        .s_readdata_i      (s_readdata)
    );

    task automatic idle_inputs();
        m_address       = '0;
        m_read          = '0;
        m_write         = '0;
        m_writedata     = '0;
        s_waitrequest   = 1'b0;
        s_readdatavalid = 1'b0;
        s_readdata      = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst = 1'b0;
            m_read = '1;
            s_readdatavalid = 1'b1;
            #1;
            n_checks++; if (s_read !== 1'b0) $display("FAIL reset_s_read c%0d got %b exp 0", c, s_read); else n_pass++;
            n_checks++; if (s_write !== 1'b0) $display("FAIL reset_s_write c%0d got %b exp 0", c, s_write); else n_pass++;
            n_checks++; if (m_waitrequest !== 2'b11) $display("FAIL reset_waitreq c%0d got %b exp 11", c, m_waitrequest); else n_pass++;
            n_checks++; if (m_readdatavalid !== 2'b00) $display("FAIL reset_rvalid c%0d got %b exp 00", c, m_readdatavalid); else n_pass++;
        end
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (m_waitrequest !== 2'b11) $display("FAIL no_req_waitreq got %b exp 11", m_waitrequest); else n_pass++;
        n_checks++; if ({s_read, s_write} !== 2'b00) $display("FAIL no_req_strobes got %b exp 00", {s_read, s_write}); else n_pass++;
    endtask

    task automatic test_single_write();
        apply_reset();
        @(negedge clk);
        m_write[0]     = 1'b1;
        m_address[0]   = 20'h00010;
        m_writedata[0] = 16'hA5A5;
        #1;
        n_checks++; if (s_write !== 1'b1) $display("FAIL single_write_s_write got %b exp 1", s_write); else n_pass++;
        n_checks++; if (s_read !== 1'b0) $display("FAIL single_write_s_read got %b exp 0", s_read); else n_pass++;
        n_checks++; if (s_address !== 20'h00010) $display("FAIL single_write_addr got %h exp 00010", s_address); else n_pass++;
        n_checks++; if (s_writedata !== 16'hA5A5) $display("FAIL single_write_data got %h exp a5a5", s_writedata); else n_pass++;
        n_checks++; if (m_waitrequest !== 2'b10) $display("FAIL single_write_waitreq got %b exp 10", m_waitrequest); else n_pass++;
        @(negedge clk);
        idle_inputs();
    endtask

`ifdef SRAM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            m_read = '1;
            m_address[0] = 20'h00100;
            m_address[1] = 20'h00200;
            s_readdatavalid = (c >= 1);
            #1;
            n_checks++; if (m_waitrequest !== 2'b10) $display("FAIL fixed_prio_waitreq c%0d got %b exp 10", c, m_waitrequest); else n_pass++;
            n_checks++; if (s_address !== 20'h00100) $display("FAIL fixed_prio_addr c%0d got %h exp 00100", c, s_address); else n_pass++;
        end
        @(negedge clk);
        idle_inputs();
    endtask
`else
    task automatic test_contention();
        logic [N-1:0]  exp_wq;
        logic [N-1:0]  exp_rv;
        logic [AW-1:0] exp_a;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            m_read          = '1;
            m_address[0]    = 20'h00100;
            m_address[1]    = 20'h00200;
            s_readdatavalid = (c >= 3);
            s_readdata      = 16'($urandom);
            #1;
            exp_wq = (c % 2 == 0) ? 2'b10 : 2'b01;
            exp_a  = (c % 2 == 0) ? 20'h00100 : 20'h00200;
            exp_rv = (c < 3) ? 2'b00 : (((c - 3) % 2 == 0) ? 2'b01 : 2'b10);
            n_checks++; if (m_waitrequest !== exp_wq) $display("FAIL contention_waitreq c%0d got %b exp %b", c, m_waitrequest, exp_wq); else n_pass++;
            n_checks++; if (s_address !== exp_a) $display("FAIL contention_addr c%0d got %h exp %h", c, s_address, exp_a); else n_pass++;
            n_checks++; if (m_readdatavalid !== exp_rv) $display("FAIL contention_rvalid c%0d got %b exp %b", c, m_readdatavalid, exp_rv); else n_pass++;
            n_checks++; if (m_readdata !== s_readdata) $display("FAIL contention_rdata c%0d got %h exp %h", c, m_readdata, s_readdata); else n_pass++;
        end
        @(negedge clk);
        idle_inputs();
    endtask
`endif

    task automatic test_stall_lock();
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            m_address[0]   = 20'h00300;
            m_address[1]   = 20'h00400;
            m_writedata[1] = 16'hBEEF;
            m_write[1]     = (c <= 5);
            m_read[0]      = (c >= 1);
            s_waitrequest  = (c <= 4);
            #1;
            if (c <= 4) begin
                n_checks++; if (s_write !== 1'b1 || s_read !== 1'b0) $display("FAIL stall_strobes c%0d got %b%b exp 01", c, s_read, s_write); else n_pass++;
                n_checks++; if (s_address !== 20'h00400) $display("FAIL stall_addr c%0d got %h exp 00400", c, s_address); else n_pass++;
                n_checks++; if (m_waitrequest !== 2'b11) $display("FAIL stall_waitreq c%0d got %b exp 11", c, m_waitrequest); else n_pass++;
            end else if (c == 5) begin
                n_checks++; if (m_waitrequest !== 2'b01) $display("FAIL stall_release_waitreq got %b exp 01", m_waitrequest); else n_pass++;
                n_checks++; if (s_writedata !== 16'hBEEF) $display("FAIL stall_release_wdata got %h exp beef", s_writedata); else n_pass++;
            end else begin
                n_checks++; if (m_waitrequest !== 2'b10) $display("FAIL stall_next_waitreq got %b exp 10", m_waitrequest); else n_pass++;
                n_checks++; if (s_read !== 1'b1) $display("FAIL stall_next_s_read got %b exp 1", s_read); else n_pass++;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        logic         sr_tab [9];
        logic         sw_tab [9];
        logic [N-1:0] wq_tab [9];
        logic [N-1:0] rv_tab [9];
        sr_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        sw_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        wq_tab = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01};
        rv_tab = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            m_address[0]    = 20'h00500;
            m_address[1]    = 20'h00600;
            m_writedata[1]  = 16'h1234;
            m_read[0]       = (c <= 7);
            m_write[1]      = (c >= 5);
            s_readdatavalid = (c == 6);
            #1;
            n_checks++; if (s_read !== sr_tab[c]) $display("FAIL fifo_full_s_read c%0d got %b exp %b", c, s_read, sr_tab[c]); else n_pass++;
            n_checks++; if (s_write !== sw_tab[c]) $display("FAIL fifo_full_s_write c%0d got %b exp %b", c, s_write, sw_tab[c]); else n_pass++;
            n_checks++; if (m_waitrequest !== wq_tab[c]) $display("FAIL fifo_full_waitreq c%0d got %b exp %b", c, m_waitrequest, wq_tab[c]); else n_pass++;
            n_checks++; if (m_readdatavalid !== rv_tab[c]) $display("FAIL fifo_full_rvalid c%0d got %b exp %b", c, m_readdatavalid, rv_tab[c]); else n_pass++;
        end
        n_checks++; if (s_address !== 20'h00600) $display("FAIL fifo_full_write_addr got %h exp 00600", s_address); else n_pass++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m_address[0] = 20'h00700;
        m_address[1] = 20'h00800;
        @(negedge clk);
        m_read = 2'b11;
        #1;
        n_checks++; if (m_waitrequest !== 2'b10) $display("FAIL rmid_read0 got %b exp 10", m_waitrequest); else n_pass++;
        @(negedge clk);
        m_read = 2'b10;
        #1;
        n_checks++; if (m_waitrequest !== 2'b01) $display("FAIL rmid_read1 got %b exp 01", m_waitrequest); else n_pass++;
        @(negedge clk);
        m_read = 2'b00;
        m_write = 2'b10;
        s_waitrequest = 1'b1;
        #1;
        n_checks++; if (m_waitrequest !== 2'b11 || s_write !== 1'b1) $display("FAIL rmid_lock got %b/%b exp 11/1", m_waitrequest, s_write); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        s_readdatavalid = 1'b1;
        #1;
        n_checks++; if ({s_read, s_write, m_waitrequest, m_readdatavalid} !== 6'b001100) $display("FAIL rmid_in_reset got %b exp 001100", {s_read, s_write, m_waitrequest, m_readdatavalid}); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        s_readdatavalid = 1'b0;
        s_waitrequest = 1'b0;
        m_write = 2'b11;
        #1;
        n_checks++; if (m_waitrequest !== 2'b10) $display("FAIL rmid_after_waitreq got %b exp 10", m_waitrequest); else n_pass++;
        n_checks++; if (s_address !== 20'h00700) $display("FAIL rmid_after_addr got %h exp 00700", s_address); else n_pass++;
        for (int c = 0; c < MP; c++) begin
            @(negedge clk);
            m_write = 2'b00;
            m_read  = 2'b01;
            #1;
            n_checks++; if (s_read !== 1'b1 || m_waitrequest !== 2'b10) $display("FAIL rmid_fifo_empty c%0d got %b/%b exp 1/10", c, s_read, m_waitrequest); else n_pass++;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    // Reference model: list of pending read owners, rotating pointer, held grant.
    task automatic test_random();
        bit            cmd_act  [N];
        bit            cmd_rd   [N];
        logic [AW-1:0] cmd_addr [N];
        logic [DW-1:0] cmd_data [N];
        int            q[$];
        int            rr;
        bit            locked;
        int            lid;
        int            g;
        int            k;
        bit            gv, isr, isw, thr, acc, e_sr, e_sw;
        logic [N-1:0]  e_wq;
        logic [N-1:0]  e_rv;
        apply_reset();
        rr = 0;
        locked = 1'b0;
        lid = 0;
        for (int m = 0; m < N; m++) cmd_act[m] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int m = 0; m < N; m++) begin
                if (!cmd_act[m] && $urandom_range(0, 1) == 1) begin
                    cmd_act[m]  = 1'b1;
                    cmd_rd[m]   = ($urandom_range(0, 1) == 1);
                    cmd_addr[m] = AW'($urandom);
                    cmd_data[m] = DW'($urandom);
                end
                m_read[m]      = cmd_act[m] && cmd_rd[m];
                m_write[m]     = cmd_act[m] && !cmd_rd[m];
                m_address[m]   = cmd_addr[m];
                m_writedata[m] = cmd_data[m];
            end
            s_waitrequest   = ($urandom_range(0, 3) == 0);
            s_readdatavalid = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            s_readdata      = DW'($urandom);
            #1;
            gv = 1'b0;
            g  = 0;
            if (locked) begin
                g  = lid;
                gv = cmd_act[g];
            end else begin
                for (int i = 0; i < N; i++) begin
                    k = (rr + i) % N;
                    if (!gv && cmd_act[k]) begin
                        gv = 1'b1;
                        g  = k;
                    end
                end
            end
            isr  = gv && cmd_rd[g];
            isw  = gv && !cmd_rd[g];
            thr  = isr && (q.size() >= MP);
            e_sr = isr && !thr;
            e_sw = isw;
            e_wq = '1;
            if (gv) e_wq[g] = s_waitrequest || thr;
            e_rv = '0;
            if (s_readdatavalid && q.size() > 0) e_rv[q[0]] = 1'b1;
            acc = (e_sr || e_sw) && !s_waitrequest;
            n_checks++; if (s_read !== e_sr) $display("FAIL rand_s_read c%0d got %b exp %b", c, s_read, e_sr); else n_pass++;
            n_checks++; if (s_write !== e_sw) $display("FAIL rand_s_write c%0d got %b exp %b", c, s_write, e_sw); else n_pass++;
            n_checks++; if (m_waitrequest !== e_wq) $display("FAIL rand_waitreq c%0d got %b exp %b", c, m_waitrequest, e_wq); else n_pass++;
            n_checks++; if (m_readdatavalid !== e_rv) $display("FAIL rand_rvalid c%0d got %b exp %b", c, m_readdatavalid, e_rv); else n_pass++;
            if (e_sr || e_sw) begin
                n_checks++; if (s_address !== cmd_addr[g]) $display("FAIL rand_addr c%0d got %h exp %h", c, s_address, cmd_addr[g]); else n_pass++;
            end
            if (e_sw) begin
                n_checks++; if (s_writedata !== cmd_data[g]) $display("FAIL rand_wdata c%0d got %h exp %h", c, s_writedata, cmd_data[g]); else n_pass++;
            end
            if (s_readdatavalid && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                if (isr) q.push_back(g);
`ifndef SRAM_ARB_FIXED_PRIO_EN
                rr = (g + 1) % N;
`endif
                locked     = 1'b0;
                cmd_act[g] = 1'b0;
            end else begin
                locked = gv;
                lid    = g;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
`ifdef SRAM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_contention();
`endif
        test_stall_lock();
        test_fifo_full();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
